bomb_drop_ctrl: RTL

- Upstream position/state generator for the bomb sprite renderer on the 96x64 OLED.
- Accepts a drop request with a column, then animates a gravity fall once per display frame.
- At the ground row it holds an explosion phase for a fixed number of frames, then returns to idle.
- Drives the sprite's x/y origin plus visibility/explosion flags consumed by the renderer and the pixel mux.

---
 rtl/oled_pkg.sv | 26 ++
 rtl/frame_tick_gen.sv | 27 ++
 rtl/bomb_drop_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared 96x64 OLED geometry and sprite-controller state encoding.
// Declarations only: no latency, no flow control.
// Imported by every sprite controller that tracks the panel scan.
package oled_pkg;

  localparam int SCREEN_W    = 96;
  localparam int SCREEN_H    = 64;
  localparam int PIXEL_COUNT = SCREEN_W * SCREEN_H;
  localparam int PIX_W       = $clog2(PIXEL_COUNT);
  localparam int COORD_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALL    = 2'd1,
    ST_EXPLODE = 2'd2
  } sprite_state_t;

  // Keeps a sprite of the given width fully on screen horizontally.
  function automatic logic [COORD_W-1:0] clamp_col(input logic [COORD_W-1:0] col,
                                                   input int sprite_w);
    logic [COORD_W-1:0] lim;
    lim = COORD_W'(SCREEN_W - sprite_w);
    return (col > lim) ? lim : col;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Detects the OLED scan wrapping back to pixel 0 and emits a one-cycle frame_tick.
// Latency: tick is registered, high the cycle after pixel_index first reads 0.
// No backpressure; an index parked at 0 yields a single tick.
module frame_tick_gen
  import oled_pkg::*;
#(
  parameter int IDX_W = PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] pixel_index,
  output logic             frame_tick
);

  logic [IDX_W-1:0] prev_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_index <= '0;
      frame_tick <= 1'b0;
    end else begin
      prev_index <= pixel_index;
      frame_tick <= (pixel_index == '0) && (prev_index != '0);
    end
  end

endmodule

// File: rtl/bomb_drop_ctrl.sv
// Bomb sprite position/state generator: accepts a drop, falls under gravity per frame, explodes, idles.
// Latency: drop_ack same cycle as acceptance; x/y/flags/done registered, valid the cycle after each update.
// No backpressure: drop_req while busy is dropped; abort cancels in one cycle.
module bomb_drop_ctrl
  import oled_pkg::*;
#(
  parameter int SPRITE_W       = 10,
  parameter int GROUND_Y       = 50,
  parameter int MAX_VEL        = 4,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pixel_index,
  input  logic               drop_req,
  input  logic [COORD_W-1:0] drop_x,
  input  logic               abort,
  output logic               drop_ack,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               visible,
  output logic               exploding,
  output logic               busy,
  output logic               done
);

  localparam int VEL_W = $clog2(MAX_VEL + 1);
  localparam int CNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam int SUM_W = COORD_W + 1;

  localparam logic [VEL_W-1:0]   VEL_MAX    = VEL_W'(MAX_VEL);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [SUM_W-1:0]   GROUND_SUM = SUM_W'(GROUND_Y);
  localparam logic [COORD_W-1:0] GROUND_ROW = COORD_W'(GROUND_Y);

  sprite_state_t    state;
  sprite_state_t    state_nxt;
  logic             frame_tick;
  logic [VEL_W-1:0] vel;
  logic [VEL_W-1:0] vel_nxt;
  logic [CNT_W-1:0] expl_cnt;
  logic [SUM_W-1:0] fall_sum;
  logic             land;
  logic             expl_last;
  logic             accept;

  frame_tick_gen #(
    .IDX_W(PIX_W)
  ) u_frame_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_index(pixel_index),
    .frame_tick (frame_tick)
  );

  // One extra bit on the sum so a near-ground step can never wrap past GROUND_Y.
  always_comb begin
    vel_nxt   = (vel >= VEL_MAX) ? VEL_MAX : vel + 1'b1;
    fall_sum  = {1'b0, y} + SUM_W'(vel_nxt);
    land      = (fall_sum >= GROUND_SUM);
    expl_last = (expl_cnt == CNT_LAST);
    accept    = (state == ST_IDLE) && drop_req && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_FALL;
      end
      ST_FALL: begin
        if (abort)                   state_nxt = ST_IDLE;
        else if (frame_tick && land) state_nxt = ST_EXPLODE;
      end
      ST_EXPLODE: begin
        if (abort)                        state_nxt = ST_IDLE;
        else if (frame_tick && expl_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    visible   = (state == ST_FALL) || (state == ST_EXPLODE);
    exploding = (state == ST_EXPLODE);
    drop_ack  = accept && rst_n;
  end

  // Abort freezes x/y where they are; only an accepted drop reloads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      vel      <= '0;
      expl_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        x        <= clamp_col(drop_x, SPRITE_W);
        y        <= '0;
        vel      <= '0;
        expl_cnt <= '0;
      end else if (frame_tick && !abort) begin
        if (state == ST_FALL) begin
          vel <= vel_nxt;
          if (land) begin
            y        <= GROUND_ROW;
            expl_cnt <= '0;
          end else begin
            y <= fall_sum[COORD_W-1:0];
          end
        end else if (state == ST_EXPLODE) begin
          if (expl_last) done <= 1'b1;
          else           expl_cnt <= expl_cnt + 1'b1;
        end
      end
    end
  end

endmodule
